hull_fifo_thresh: RTL and testbench
===================================

Name: hull_fifo_thresh

Overview:
- Parametrised single-clock FIFO; next-generation replacement for the team's basic small FIFO.
- Adds selectable read mode (first-word-fall-through or registered standard read), a fill-level output and programmable almost-full/almost-empty thresholds.
- Adds a synchronous flush and sticky overflow/underflow error flags.
- Sits between pagerank pipeline stages (edge/vertex streams) where producers need early back-pressure and debug visibility.

Parameters:
- WIDTH, 64, data word width in bits (>=1).
- LOG_DEPTH, 2, log2 of entry count; DEPTH = 2**LOG_DEPTH; LOG_DEPTH >= 1.
- FWFT, 1, 1 = head word visible on rd_data while !empty; 0 = registered read, data valid one cycle after an accepted rd_en.
- AF_LEVEL, DEPTH-1, almost_full asserted when level >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserted when level <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of contents; pointers and level go to 0, memory is not cleared.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_LEVEL.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data; meaning depends on FWFT.
- rd_valid  out  1  FWFT=1: equals !empty; FWFT=0: one-cycle pulse, rd_data valid.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  LOG_DEPTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.

Behaviour:
- Accept conditions:
  - Write is accepted iff wr_en && !full && !flush.
  - Read is accepted iff rd_en && !empty && !flush.
  - full and empty are taken from registered state at the start of the cycle.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH, wrapping naturally.
- Accepted read: rd_ptr increments modulo DEPTH.
- Level update:
  - Read and write both accepted: level unchanged.
  - Write only: level + 1.
  - Read only: level - 1.
- Full with rd_en && wr_en: the read is accepted and the write is rejected; overflow is set; level drops to DEPTH-1.
- Empty with rd_en && wr_en: the write is accepted and the read is rejected; underflow is set; level rises to 1.
- Flush:
  - Next cycle: wr_ptr = rd_ptr = level = 0, overflow = underflow = 0, rd_valid = 0.
  - Any same-cycle wr_en/rd_en is ignored and does not set error flags.
  - rd_data (FWFT=0) holds its old value.
- Reset: all outputs in the cycle after rst is sampled high:
  - level = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0.
  - rd_data = 0 when FWFT=0.
  - Memory contents are not reset.
- Reset asserted mid-stream discards all contents; the same applies to rst and flush together.
- FWFT=1: rd_data = mem[rd_ptr] combinationally. The value is defined only while !empty. Data for an accepted read is consumed in the same cycle; a word written into an empty FIFO appears on rd_data the next cycle.
- FWFT=0: on an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1 in the next cycle. Otherwise rd_valid <= 0 and rd_data holds its value. Read latency is 1.
- Status outputs: full, empty, almost_full, almost_empty and level are pure functions of the level register, so they are glitch-free and registered-equivalent.
- Error flags stay set until rst or flush.

Decomposition:
- Package hull_fifo_pkg:
  - FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
  - Function clog2.
  - Parameter-legality check macros (AF_LEVEL/AE_LEVEL range), elaboration-time assertions.
- Sub-module hull_fifo_ram: simple dual-port memory, one synchronous write port and one asynchronous read port, parametrised WIDTH/LOG_DEPTH. The FWFT=0 output register lives in the top.

Test Plan (LOG_DEPTH=2, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1 unless stated):
- Reset then idle → level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0.
- Write 0x11,0x22,0x33,0x44 back-to-back → level 1,2,3,4; almost_empty drops at level 2; almost_full rises at 3; full at 4. A 5th write (0x55) sets overflow, level stays 4.
- Full FIFO, rd_en=wr_en=1 with 0x99 → 0x11 read, write rejected, overflow=1, level=3. Drain returns 0x22,0x33,0x44 with pointer wrap, then empty=1.
- Empty FIFO, rd_en=wr_en=1 with 0xAB → underflow=1, level=1. FWFT=1: rd_data=0xAB next cycle. FWFT=0: next read gives rd_valid pulse with 0xAB one cycle later.
- FWFT=0: steady alternating writes and reads of 0x01..0x08 → each rd_valid pulse one cycle after rd_en carries the matching in-order value; rd_data holds between pulses.
- Level 3 plus overflow set, assert flush with wr_en=1 → next cycle level=0, empty=1, overflow=0, write discarded. Repeat with rst asserted after 2 writes → identical cleared state.

Source files
------------

// File: rtl/hull_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the hull FIFO family.
package hull_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // almost_full threshold must be reachable and non-trivial: 1..DEPTH.
  function automatic bit af_level_ok(input int af, input int log_depth);
    return (af >= 1) && (af <= (1 << log_depth));
  endfunction

  // almost_empty threshold must leave full distinguishable: 0..DEPTH-1.
  function automatic bit ae_level_ok(input int ae, input int log_depth);
    return (ae >= 0) && (ae <= (1 << log_depth) - 1);
  endfunction

endpackage

// File: rtl/hull_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module hull_fifo_ram #(
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [LOG_DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [LOG_DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is never reset; only the write port updates it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hull_fifo_thresh.sv
// Single-clock FIFO with FWFT/standard read, fill level, programmable
// almost-full/almost-empty thresholds, flush and sticky error flags.
module hull_fifo_thresh
  import hull_fifo_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 2,
  parameter int FWFT      = FIFO_MODE_FWFT,
  parameter int AF_LEVEL  = (1 << LOG_DEPTH) - 1,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] LVL_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] LVL_AF   = (LOG_DEPTH+1)'(AF_LEVEL);
  localparam logic [LOG_DEPTH:0] LVL_AE   = (LOG_DEPTH+1)'(AE_LEVEL);

  // Reject illegal thresholds at elaboration rather than misbehave silently.
  if (LOG_DEPTH < 1) begin : g_bad_depth
    $error("hull_fifo_thresh: LOG_DEPTH must be >= 1");
  end
  if (!af_level_ok(AF_LEVEL, LOG_DEPTH)) begin : g_bad_af
    $error("hull_fifo_thresh: AF_LEVEL outside 1..DEPTH");
  end
  if (!ae_level_ok(AE_LEVEL, LOG_DEPTH)) begin : g_bad_ae
    $error("hull_fifo_thresh: AE_LEVEL outside 0..DEPTH-1");
  end

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 wr_acc, rd_acc;
  logic [WIDTH-1:0]     ram_rdata;

  // Status is decoded from the level register alone, so it is glitch-free.
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Flush suppresses both ports; full/empty come from start-of-cycle state,
  // so a full FIFO still drains and an empty one still fills.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (wr_en && full)  ovf_d = 1'b1;
      if (rd_en && empty) unf_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Gate writes during reset so a discarded word never lands in storage.
  hull_fifo_ram #(
    .WIDTH     (WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Registered read: one-cycle valid pulse, data held between pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_hull_fifo_thresh.sv
// Bench: FWFT and standard-read instances driven in lockstep, checked
// against directed expectations and a queue-based reference model.
module tb_hull_fifo_thresh;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  // Index 0: FWFT=1 instance, index 1: FWFT=0 instance.
  logic       full_w [2], af_w [2], rdv_w [2], empty_w [2], ae_w [2];
  logic       ovf_w [2], unf_w [2];
  logic [7:0] rdd [2];
  logic [2:0] lvl [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  logic [7:0] q [$];
  logic       m_ovf, m_unf, m_sv;
  logic [7:0] m_sd;

  always #5 clk = ~clk;

  hull_fifo_thresh #(.WIDTH(8), .LOG_DEPTH(2), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_w[0]), .almost_full(af_w[0]), .rd_en(rd_en), .rd_data(rdd[0]),
    .rd_valid(rdv_w[0]), .empty(empty_w[0]), .almost_empty(ae_w[0]), .level(lvl[0]),
    .overflow(ovf_w[0]), .underflow(unf_w[0]));

  hull_fifo_thresh #(.WIDTH(8), .LOG_DEPTH(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_w[1]), .almost_full(af_w[1]), .rd_en(rd_en), .rd_data(rdd[1]),
    .rd_valid(rdv_w[1]), .empty(empty_w[1]), .almost_empty(ae_w[1]), .level(lvl[1]),
    .overflow(ovf_w[1]), .underflow(unf_w[1]));

  // Apply one cycle of inputs, advance past the edge, update the model.
  task automatic drive(input logic r, input logic f, input logic w,
                       input logic [7:0] d, input logic rd);
    bit was_full, was_empty;
    rst = r; flush = f; wr_en = w; wr_data = d; rd_en = rd;
    @(posedge clk); #1;
    if (r) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_sv = 0; m_sd = 8'h00;
    end else if (f) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_sv = 0;
    end else begin
      was_full  = (q.size() == 4);
      was_empty = (q.size() == 0);
      if (w && was_full)  m_ovf = 1;
      if (rd && was_empty) m_unf = 1;
      if (rd && !was_empty) begin m_sd = q.pop_front(); m_sv = 1; end
      else m_sv = 0;
      if (w && !was_full) q.push_back(d);
    end
    rst = 0; flush = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (lvl[k] !== 3'd0) $display("FAIL reset_level[%0d] got %0d want 0", k, lvl[k]); else n_pass++;
      n_chk++; if (empty_w[k] !== 1'b1 || ae_w[k] !== 1'b1) $display("FAIL reset_empty[%0d] got e=%b ae=%b want 1/1", k, empty_w[k], ae_w[k]); else n_pass++;
      n_chk++; if (full_w[k] !== 1'b0 || af_w[k] !== 1'b0) $display("FAIL reset_full[%0d] got f=%b af=%b want 0/0", k, full_w[k], af_w[k]); else n_pass++;
      n_chk++; if (ovf_w[k] !== 1'b0 || unf_w[k] !== 1'b0) $display("FAIL reset_err[%0d] got o=%b u=%b want 0/0", k, ovf_w[k], unf_w[k]); else n_pass++;
      n_chk++; if (rdv_w[k] !== 1'b0) $display("FAIL reset_rdv[%0d] got %b want 0", k, rdv_w[k]); else n_pass++;
    end
    n_chk++; if (rdd[1] !== 8'h00) $display("FAIL reset_rdata_std got %h want 00", rdd[1]); else n_pass++;
  endtask

  task automatic test_fill();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, v[i-1], 0);
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (lvl[k] !== 3'(i)) $display("FAIL fill_level[%0d] got %0d want %0d", k, lvl[k], i); else n_pass++;
        n_chk++; if (ae_w[k] !== (i <= 1) || af_w[k] !== (i >= 3) || full_w[k] !== (i == 4))
          $display("FAIL fill_flags[%0d] lvl %0d got ae=%b af=%b f=%b", k, i, ae_w[k], af_w[k], full_w[k]); else n_pass++;
      end
      n_chk++; if (rdd[0] !== 8'h11) $display("FAIL fill_fwft_head got %h want 11", rdd[0]); else n_pass++;
    end
    drive(0, 0, 1, 8'h55, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (ovf_w[k] !== 1'b1 || lvl[k] !== 3'd4) $display("FAIL fill_overflow[%0d] got o=%b lvl=%0d want 1/4", k, ovf_w[k], lvl[k]); else n_pass++;
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_d [3] = '{8'h22, 8'h33, 8'h44};
    drive(0, 0, 1, 8'h99, 1);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (lvl[k] !== 3'd3 || ovf_w[k] !== 1'b1) $display("FAIL fullrw_state[%0d] got lvl=%0d o=%b want 3/1", k, lvl[k], ovf_w[k]); else n_pass++;
    end
    n_chk++; if (rdv_w[1] !== 1'b1 || rdd[1] !== 8'h11) $display("FAIL fullrw_std got v=%b d=%h want 1/11", rdv_w[1], rdd[1]); else n_pass++;
    for (int j = 0; j < 3; j++) begin
      n_chk++; if (rdd[0] !== exp_d[j]) $display("FAIL drain_fwft got %h want %h", rdd[0], exp_d[j]); else n_pass++;
      drive(0, 0, 0, 8'h00, 1);
      n_chk++; if (rdv_w[1] !== 1'b1 || rdd[1] !== exp_d[j]) $display("FAIL drain_std got v=%b d=%h want 1/%h", rdv_w[1], rdd[1], exp_d[j]); else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (empty_w[k] !== 1'b1 || rdv_w[0] !== 1'b0) $display("FAIL drain_empty[%0d] got e=%b v0=%b want 1/0", k, empty_w[k], rdv_w[0]); else n_pass++;
    end
  endtask

  task automatic test_empty_rw();
    drive(0, 0, 1, 8'hAB, 1);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (unf_w[k] !== 1'b1 || lvl[k] !== 3'd1) $display("FAIL emptyrw_state[%0d] got u=%b lvl=%0d want 1/1", k, unf_w[k], lvl[k]); else n_pass++;
    end
    n_chk++; if (rdd[0] !== 8'hAB || rdv_w[0] !== 1'b1) $display("FAIL emptyrw_fwft got d=%h v=%b want ab/1", rdd[0], rdv_w[0]); else n_pass++;
    n_chk++; if (rdv_w[1] !== 1'b0) $display("FAIL emptyrw_std_novalid got %b want 0", rdv_w[1]); else n_pass++;
    drive(0, 0, 0, 8'h00, 1);
    n_chk++; if (rdv_w[1] !== 1'b1 || rdd[1] !== 8'hAB) $display("FAIL emptyrw_std got v=%b d=%h want 1/ab", rdv_w[1], rdd[1]); else n_pass++;
    drive(0, 0, 0, 8'h00, 0);
    n_chk++; if (rdv_w[1] !== 1'b0 || rdd[1] !== 8'hAB) $display("FAIL emptyrw_hold got v=%b d=%h want 0/ab", rdv_w[1], rdd[1]); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [7:0] prev = 8'hAB;
    for (int v = 1; v <= 8; v++) begin
      drive(0, 0, 1, 8'(v), 0);
      n_chk++; if (rdv_w[1] !== 1'b0 || rdd[1] !== prev) $display("FAIL alt_hold got v=%b d=%h want 0/%h", rdv_w[1], rdd[1], prev); else n_pass++;
      drive(0, 0, 0, 8'h00, 1);
      n_chk++; if (rdv_w[1] !== 1'b1 || rdd[1] !== 8'(v)) $display("FAIL alt_read got v=%b d=%h want 1/%h", rdv_w[1], rdd[1], 8'(v)); else n_pass++;
      prev = 8'(v);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'hA0 + 8'(i), 0);
    drive(0, 0, 0, 8'h00, 1);
    n_chk++; if (lvl[1] !== 3'd3 || ovf_w[1] !== 1'b1) $display("FAIL preflush got lvl=%0d o=%b want 3/1", lvl[1], ovf_w[1]); else n_pass++;
    drive(0, 1, 1, 8'h77, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (lvl[k] !== 3'd0 || empty_w[k] !== 1'b1) $display("FAIL flush_level[%0d] got lvl=%0d e=%b want 0/1", k, lvl[k], empty_w[k]); else n_pass++;
      n_chk++; if (ovf_w[k] !== 1'b0 || unf_w[k] !== 1'b0 || rdv_w[k] !== 1'b0) $display("FAIL flush_flags[%0d] got o=%b u=%b v=%b want 0/0/0", k, ovf_w[k], unf_w[k], rdv_w[k]); else n_pass++;
    end
    n_chk++; if (rdd[1] !== 8'hA0) $display("FAIL flush_hold got %h want a0", rdd[1]); else n_pass++;
    drive(0, 0, 0, 8'h00, 0);
    n_chk++; if (lvl[0] !== 3'd0) $display("FAIL flush_discard got lvl=%0d want 0", lvl[0]); else n_pass++;
    drive(0, 0, 1, 8'hB0, 0);
    drive(0, 0, 1, 8'hB1, 0);
    drive(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (lvl[k] !== 3'd0 || empty_w[k] !== 1'b1 || ovf_w[k] !== 1'b0 || unf_w[k] !== 1'b0)
        $display("FAIL midrst[%0d] got lvl=%0d e=%b o=%b u=%b want 0/1/0/0", k, lvl[k], empty_w[k], ovf_w[k], unf_w[k]); else n_pass++;
    end
    n_chk++; if (rdd[1] !== 8'h00 || rdv_w[1] !== 1'b0) $display("FAIL midrst_std got d=%h v=%b want 00/0", rdd[1], rdv_w[1]); else n_pass++;
    drive(0, 0, 1, 8'hC0, 0);
    drive(1, 1, 1, 8'hC1, 1);
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (lvl[k] !== 3'd0 || empty_w[k] !== 1'b1 || rdv_w[k] !== 1'b0) $display("FAIL rstflush[%0d] got lvl=%0d e=%b v=%b want 0/1/0", k, lvl[k], empty_w[k], rdv_w[k]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int sz;
    for (int c = 0; c < 400; c++) begin
      if (q.size() != 0) begin
        n_chk++; if (rdd[0] !== q[0]) $display("FAIL rnd_fwft_head cyc %0d got %h want %h", c, rdd[0], q[0]); else n_pass++;
      end
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5);
      sz = q.size();
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (lvl[k] !== 3'(sz)) $display("FAIL rnd_level[%0d] cyc %0d got %0d want %0d", k, c, lvl[k], sz); else n_pass++;
        n_chk++; if (full_w[k] !== (sz == 4) || empty_w[k] !== (sz == 0) || af_w[k] !== (sz >= 3) || ae_w[k] !== (sz <= 1))
          $display("FAIL rnd_status[%0d] cyc %0d got f=%b e=%b af=%b ae=%b lvl_model=%0d", k, c, full_w[k], empty_w[k], af_w[k], ae_w[k], sz); else n_pass++;
        n_chk++; if (ovf_w[k] !== m_ovf || unf_w[k] !== m_unf)
          $display("FAIL rnd_err[%0d] cyc %0d got o=%b u=%b want %b/%b", k, c, ovf_w[k], unf_w[k], m_ovf, m_unf); else n_pass++;
      end
      n_chk++; if (rdv_w[0] !== (sz != 0)) $display("FAIL rnd_fwft_valid cyc %0d got %b want %b", c, rdv_w[0], sz != 0); else n_pass++;
      n_chk++; if (rdv_w[1] !== m_sv || rdd[1] !== m_sd)
        $display("FAIL rnd_std cyc %0d got v=%b d=%h want %b/%h", c, rdv_w[1], rdd[1], m_sv, m_sd); else n_pass++;
    end
  endtask

  initial begin
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; wr_data = 8'h00;
    m_ovf = 0; m_unf = 0; m_sv = 0; m_sd = 8'h00;
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_alternate();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
